// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter slice.
package gray_pkg;

  // up_dn encoding
  localparam logic GRAY_UP = 1'b1;
  localparam logic GRAY_DN = 1'b0;

  // Widest vector the conversion helper handles; narrower callers zero-pad.
  localparam int unsigned GRAY_MAX_W = 32;

  // Binary to reflected Gray code. Zero-padded inputs convert correctly because
  // the padding bits shift in as zeros above the real MSB.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_n.sv
// Parameterised combinational binary-to-Gray converter.
module bin2gray_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  logic [GRAY_MAX_W-1:0] bin_wide;
  logic [GRAY_MAX_W-1:0] gray_wide;
  logic                  unused_gray_wide;

  // Zero-extend to the helper's width, convert, and keep the low WIDTH bits.
  always_comb begin
    bin_wide              = '0;
    bin_wide[WIDTH-1:0]   = bin_i;
    gray_wide             = bin2gray(bin_wide);
    gray_o                = gray_wide[WIDTH-1:0];
    // Upper bits are always zero; reduce them so nothing is left dangling.
    unused_gray_wide      = ^gray_wide;
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down, loadable, wrap-or-saturate binary counter with registered Gray output
// behind a valid/ready handshake. One value per accepted handshake.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap,
  output logic             busy
);

  logic [WIDTH-1:0] binary_q, binary_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  logic accept;
  logic slot_free;
  logic at_max;
  logic at_min;
  logic boundary;

  // Handshake and boundary detection from the current registered value.
  always_comb begin
    accept    = valid_q & out_ready;
    slot_free = ~valid_q | accept;
    busy      = valid_q & ~out_ready;
    at_max    = (binary_q == {WIDTH{1'b1}});
    at_min    = (binary_q == '0);
    boundary  = (up_dn == GRAY_UP) ? at_max : at_min;
  end

  // Next-state: load beats step; both are dropped while the output slot is stalled.
  always_comb begin
    binary_d = binary_q;
    wrap_d   = wrap_q;
    valid_d  = valid_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (slot_free) begin
      if (load) begin
        binary_d = load_value;
        wrap_d   = 1'b0;
        valid_d  = 1'b1;
      end else if (en) begin
        if (boundary && !WRAP) begin
          // Saturate: the repeated value is still emitted, flagged by wrap.
          binary_d = binary_q;
        end else if (up_dn == GRAY_UP) begin
          binary_d = binary_q + WIDTH'(1);
        end else begin
          binary_d = binary_q - WIDTH'(1);
        end
        wrap_d  = boundary;
        valid_d = 1'b1;
      end
    end
  end

  // Gray is derived from the next binary so both registers stay bit-aligned.
  bin2gray_n #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin_i  (binary_d),
    .gray_o (gray_d)
  );

  // Output register stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      binary_q <= '0;
      gray_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      binary_q <= binary_d;
      gray_q   <= gray_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  end

  assign binary    = binary_q;
  assign gray      = gray_q;
  assign out_valid = valid_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Sequential source stage that feeds the binary-to-Gray conversion path.
- Holds a WIDTH-bit binary count: up/down, loadable, wrap or saturate.
- Presents the binary count and its Gray encoding together, registered, behind a valid/ready handshake.
- Downstream consumers (pointer comparators, encoder checkers) take one value per handshake.

Parameters:
- WIDTH, 4, count and Gray width in bits (>=2).
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  request one count step
- up_dn  in  1  1 = increment, 0 = decrement; sampled with en
- load  in  1  request load of load_value; priority over en
- load_value  in  WIDTH  binary value to load
- binary  out  WIDTH  registered binary count
- gray  out  WIDTH  registered Gray code of binary (binary ^ (binary>>1)); always bit-aligned with binary
- out_valid  out  1  binary/gray/wrap hold a new, unaccepted value
- out_ready  in  1  downstream accepts when out_valid & out_ready
- wrap  out  1  boundary event on the step that produced the current value
- busy  out  1  combinational out_valid & ~out_ready; en/load ignored this cycle

Behaviour:
- Reset (rst=1 at clock edge): binary=0, gray=0, out_valid=0, wrap=0. rst overrides all other inputs, including an in-flight unaccepted value, which is discarded.
- accept = out_valid & out_ready. slot_free = ~out_valid | accept.
- Load, when load & slot_free:
  - binary<=load_value, gray<=load_value^(load_value>>1), wrap<=0, out_valid<=1.
  - en is ignored that cycle.
- Step, when en & ~load & slot_free:
  - Up: binary<=binary+1.
  - Down: binary<=binary-1.
  - gray updates in the same edge from the next binary. out_valid<=1.
- Boundary, up at all-ones or down at zero:
  - WRAP=1: value wraps (all-ones->0, 0->all-ones); wrap<=1.
  - WRAP=0: value unchanged; wrap<=1; out_valid<=1 (repeat value is still emitted).
  - Any non-boundary step: wrap<=0.
- accept with no load/en: out_valid<=0; binary/gray/wrap hold.
- accept with load or en in the same cycle: the new value replaces the old one back-to-back; out_valid stays 1. Throughput is 1 value/cycle.
- Stall, when out_valid & ~out_ready:
  - load and en are dropped, not queued.
  - binary, gray and wrap are held stable.
  - Upstream must hold its request until busy=0.
- Latency: request accepted at edge N -> value and out_valid visible after edge N. One register stage; no combinational path from en/load to outputs.
- Invariant: gray == binary ^ (binary>>1) in every cycle, including reset.
- Invariant, WRAP=1: consecutive emitted step values differ in exactly one gray bit.
- Invariant, WRAP=0 saturation: a repeated value differs in zero bits.
- Arithmetic: WIDTH-bit unsigned, modulo 2^WIDTH. Boundary is detected from the current binary and up_dn, not from a carry out of a wider adder.

Decomposition:
- Shared package gray_pkg: function bin2gray(WIDTH), plus constants GRAY_UP=1'b1 and GRAY_DN=1'b0 for up_dn encoding.
- One natural sub-module: bin2gray_n, a parameterised combinational converter on the next-state binary.
- Control (slot_free, next value, wrap detect) stays in gray_counter.

Test Plan (WIDTH=4 unless noted):
- Reset and free-running count:
  - Stimulus: rst=1 for 2 cycles, then out_ready=1, en=1, up_dn=1 for 17 cycles, WRAP=1.
  - Required: binary 1..15,0,1; gray 0001,0011,0010,...,1000,0000,0001.
  - Required: wrap=1 only with binary=0; one gray bit changes per value.
- Down wrap and load priority:
  - Stimulus: load=1, en=1, load_value=4'd2 in the same cycle, then en=1, up_dn=0 for 3 cycles.
  - Required: binary 2 (load wins, wrap=0), then 1, 0, 15; wrap=1 on 15; gray 15 = 1000.
- Saturate, WRAP=0:
  - Stimulus: load 4'd14, then en=1, up_dn=1 for 3 cycles.
  - Required: binary 15, 15, 15; gray 1000 each time; wrap 0, 1, 1; out_valid stays 1.
- Backpressure:
  - Stimulus: out_ready=0 after value 5 is emitted; hold en=1 for 4 cycles; then out_ready=1.
  - Required: busy=1 during the stall; binary=5 and gray=0111 stable.
  - Required: the next accepted value is 6 (gray 0101); no values are skipped or duplicated.
- Drain and idle:
  - Stimulus: emit value 9, then en=0 and out_ready=1.
  - Required: out_valid drops after one accept; binary=9 and gray=1101 held.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1, out_ready=0, binary=12.
  - Required: the next cycle shows binary=0, gray=0, out_valid=0, wrap=0, busy=0.
